// File: rtl/keccak_theta_step.sv
// +----------------------------------------------------------------------+
// | keccak_theta_step: Keccak-f[1600] theta step, one registered stage.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module keccak_theta_step #(
  parameter int X_AXIS = 5,
  parameter int Y_AXIS = 5,
  parameter int Z_AXIS = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [X_AXIS*Y_AXIS*Z_AXIS-1:0]  a_theta_in,
  input  logic                             in_valid,
  output logic [X_AXIS*Y_AXIS*Z_AXIS-1:0]  a_theta_out,
  output logic                             out_valid
);

  localparam int c_lane_bits  = Z_AXIS;
  localparam int c_sheet_bits = Y_AXIS * Z_AXIS;
  localparam int c_state_bits = X_AXIS * Y_AXIS * Z_AXIS;

  logic [X_AXIS-1:0][Z_AXIS-1:0] w_col_parity;
  logic [X_AXIS-1:0][Z_AXIS-1:0] w_theta_d;
  logic [c_state_bits-1:0]       w_theta_next;

  logic [c_state_bits-1:0]       a_theta_out_d, a_theta_out_q;
  logic                          out_valid_d, out_valid_q;

  genvar gx, gy, gz;

  generate
    for (gx = 0; gx < X_AXIS; gx++) begin : g_x
      for (gz = 0; gz < Z_AXIS; gz++) begin : g_z
        logic [Y_AXIS-1:0] w_column;
        for (gy = 0; gy < Y_AXIS; gy++) begin : g_y
          assign w_column[gy] = a_theta_in[gx*c_sheet_bits + gy*c_lane_bits + gz];
        end
        assign w_col_parity[gx][gz] = ^w_column;
        // Neighbour columns wrap in x and the right-hand one is also rotated by one in z.
        assign w_theta_d[gx][gz] =
            w_col_parity[(gx + X_AXIS - 1) % X_AXIS][gz] ^
            w_col_parity[(gx + 1) % X_AXIS][(gz + Z_AXIS - 1) % Z_AXIS];
        for (gy = 0; gy < Y_AXIS; gy++) begin : g_out
          assign w_theta_next[gx*c_sheet_bits + gy*c_lane_bits + gz] =
              a_theta_in[gx*c_sheet_bits + gy*c_lane_bits + gz] ^ w_theta_d[gx][gz];
        end
      end
    end
  endgenerate

  always_comb begin
    out_valid_d   = in_valid;
    a_theta_out_d = a_theta_out_q;
    if (in_valid) begin
      a_theta_out_d = w_theta_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_theta_out_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      a_theta_out_q <= a_theta_out_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign a_theta_out = a_theta_out_q;
  assign out_valid   = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_keccak_theta_step.sv
// Self-checking bench for keccak_theta_step against a lane/column reference model.
`default_nettype none

module tb_keccak_theta_step;

  localparam int NX = 5;
  localparam int NY = 5;
  localparam int NZ = 64;
  localparam int NB = NX * NY * NZ;

  logic          clk;
  logic          reset;
  logic [NB-1:0] a_theta_in;
  logic          in_valid;
  logic [NB-1:0] a_theta_out;
  logic          out_valid;

  int checks;
  int errors;

  keccak_theta_step #(.X_AXIS(NX), .Y_AXIS(NY), .Z_AXIS(NZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_theta_in  (a_theta_in),
    .in_valid    (in_valid),
    .a_theta_out (a_theta_out),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx(input int x, input int y, input int z);
    return x * NY * NZ + y * NZ + z;
  endfunction

  // Reference theta: column parities, then D from the two neighbour columns.
  function automatic logic [NB-1:0] theta_ref(input logic [NB-1:0] a);
    bit c [NX][NZ];
    bit d [NX][NZ];
    logic [NB-1:0] r;
    for (int x = 0; x < NX; x++)
      for (int z = 0; z < NZ; z++) begin
        c[x][z] = 1'b0;
        for (int y = 0; y < NY; y++) c[x][z] ^= a[idx(x, y, z)];
      end
    for (int x = 0; x < NX; x++)
      for (int z = 0; z < NZ; z++)
        d[x][z] = c[(x + NX - 1) % NX][z] ^ c[(x + 1) % NX][(z + NZ - 1) % NZ];
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        for (int z = 0; z < NZ; z++)
          r[idx(x, y, z)] = a[idx(x, y, z)] ^ d[x][z];
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_state();
    logic [NB-1:0] v;
    for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    int k;
    checks++;
    if (obs !== exp) begin
      errors++;
      k = -1;
      for (int i = NB - 1; i >= 0; i--) if (obs[i] !== exp[i]) k = i;
      $display("FAIL %s: got low64=%h expected low64=%h, first differing bit %0d, got ones=%0d expected ones=%0d",
               tag, obs[63:0], exp[63:0], k, $countones(obs), $countones(exp));
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    logic [NB-1:0] o;
    logic [NB-1:0] e;
    o = '0; e = '0;
    o[0] = obs; e[0] = exp;
    check(tag, o, e);
  endtask

  // Drive one valid vector and check the result one edge later.
  task automatic apply_one(input string tag, input logic [NB-1:0] v, input logic [NB-1:0] exp);
    a_theta_in = v;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    check_bit({tag, "_valid"}, out_valid, 1'b1);
    check(tag, a_theta_out, exp);
    in_valid = 1'b0;
  endtask

  logic [NB-1:0] v;
  logic [NB-1:0] e;
  logic [NB-1:0] sv [3];
  logic [NB-1:0] m_out;
  logic          m_valid;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    a_theta_in = '0;
    #1;
    check_bit("reset_valid", out_valid, 1'b0);
    check("reset_out", a_theta_out, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    apply_one("zero", '0, '0);
    apply_one("ones", '1, '1);

    v = '0; v[idx(0, 0, 0)] = 1'b1;
    e = '0; e[idx(0, 0, 0)] = 1'b1;
    for (int y = 0; y < NY; y++) begin
      e[idx(1, y, 0)] = 1'b1;
      e[idx(4, y, 1)] = 1'b1;
    end
    apply_one("single_bit", v, e);
    check_bit("single_bit_count", ($countones(a_theta_out) == 11), 1'b1);

    v = '0; v[idx(0, 2, 63)] = 1'b1;
    e = '0; e[idx(0, 2, 63)] = 1'b1;
    for (int y = 0; y < NY; y++) begin
      e[idx(1, y, 63)] = 1'b1;
      e[idx(4, y, 0)] = 1'b1;
    end
    apply_one("z_wrap", v, e);

    v = '0; v[idx(2, 0, 5)] = 1'b1; v[idx(2, 1, 5)] = 1'b1;
    apply_one("even_parity", v, v);

    // Three back-to-back vectors, then idle: output must hold the third result.
    for (int i = 0; i < 3; i++) sv[i] = rand_state();
    for (int i = 0; i < 3; i++) begin
      a_theta_in = sv[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_bit("stream_valid", out_valid, 1'b1);
      check("stream_data", a_theta_out, theta_ref(sv[i]));
    end
    in_valid = 1'b0;
    a_theta_in = rand_state();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_bit("stream_idle_valid", out_valid, 1'b0);
      check("stream_hold", a_theta_out, theta_ref(sv[2]));
    end

    // Randomised traffic against the cycle model.
    m_out = a_theta_out;
    m_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a_theta_in = rand_state();
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid) m_out = theta_ref(a_theta_in);
      m_valid = in_valid;
      @(posedge clk); #1;
      check_bit("rand_valid", out_valid, m_valid);
      check("rand_data", a_theta_out, m_out);
    end

    // Asynchronous reset mid-stream, no clock edge required.
    a_theta_in = '1; a_theta_in[0] = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_nonzero", a_theta_out, theta_ref(a_theta_in));
    #2;
    reset = 1'b1;
    #1;
    check_bit("async_reset_valid", out_valid, 1'b0);
    check("async_reset_out", a_theta_out, '0);
    @(posedge clk); #1;
    check_bit("reset_held_valid", out_valid, 1'b0);
    check("reset_held_out", a_theta_out, '0);
    v = rand_state();
    a_theta_in = v;
    reset = 1'b0;
    @(posedge clk); #1;
    check_bit("post_reset_valid", out_valid, 1'b1);
    check("post_reset_data", a_theta_out, theta_ref(v));
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keccak_theta_step.md
Name: keccak_theta_step

Overview:
- Keccak-f[1600] theta step for the SHA3-256 permutation datapath.
- Takes a full 5x5x64 state, XORs each bit with the parities of two neighbouring columns, and returns the result through one registered pipeline stage.
- Sits between the state-assembly register (which loads 8 x 200-bit input slices) and the rho/pi/chi/iota stages.

Parameters:
- X_AXIS, 5, lane count along x; must be 5.
- Y_AXIS, 5, lane count along y; must be 5.
- Z_AXIS, 64, lane width in bits; any value >= 2; z indexing is modulo Z_AXIS.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_theta_in  input  X_AXIS*Y_AXIS*Z_AXIS (1600)  state A, packed [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0].
  - Bit A[x][y][z] sits at flat index x*Y_AXIS*Z_AXIS + y*Z_AXIS + z.
  - Upstream fills it as A[x][y][z] = s[64*(5y+x)+z].
- in_valid  input  1  a_theta_in is valid this cycle.
- a_theta_out  output  1600  theta result A', same packing as a_theta_in; registered.
- out_valid  output  1  a_theta_out holds a fresh result.

Behaviour:
- Column parity: C[x][z] = XOR over y=0..4 of A[x][y][z].
- D[x][z] = C[(x-1) mod 5][z] XOR C[(x+1) mod 5][(z-1) mod Z_AXIS].
  - x=0 uses C[4]; x=4 uses C[0]; z=0 uses z-1 = Z_AXIS-1.
- A'[x][y][z] = A[x][y][z] XOR D[x][z], for all x, y, z.
- Datapath is purely combinational from a_theta_in to the output register; no multi-cycle state.
- Latency 1 cycle: on a rising edge with in_valid=1, a_theta_out <= A'(a_theta_in) and out_valid <= 1.
- On a rising edge with in_valid=0: out_valid <= 0; a_theta_out holds its previous value.
- Back-to-back in_valid gives one result per cycle; no backpressure and no stall.
- Reset is asynchronous and active-high:
  - a_theta_out = 0 and out_valid = 0 immediately, and held while reset is asserted.
  - Reset asserted mid-stream discards any in-flight result.
  - First capture occurs on the first rising edge after reset deasserts.
- Inputs with X/Z bits are not required to produce defined outputs.
- No internal state other than the output register and out_valid.

Test Plan:
- Reset: assert reset with a_theta_out previously nonzero -> a_theta_out=0 and out_valid=0 immediately (no clock edge needed); they stay 0 while reset is held.
- All-zero input, in_valid=1 -> next cycle out_valid=1, a_theta_out all zero.
- All-ones input -> every C=1, every D=0 -> a_theta_out all ones.
- Single bit A[0][0][0]=1, rest 0 -> exactly 11 output bits set:
  - A'[0][0][0];
  - A'[1][y][0] for all y (from D[1][0]);
  - A'[4][y][1] for all y (from D[4][1]).
- z wrap: single bit A[0][2][63]=1 -> set bits are:
  - A'[0][2][63];
  - A'[1][y][63] for all y;
  - A'[4][y][0] for all y.
- Even column parity: A[2][0][5]=A[2][1][5]=1 -> output equals input.
- Streaming: drive 3 consecutive valid vectors, then in_valid=0 -> out_valid is high for exactly 3 cycles with results in order; a_theta_out holds the third result afterwards.
